// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using one full-adder cell and a carry flop.
// Operands are taken through a valid/ready handshake. The sum is formed LSB-first,
// one bit per clock, and then offered through a valid/ready output handshake.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   a, b, cin           operands and carry-in to bit 0
//   out_valid/out_ready result handshake (out_valid only in DONE)
//   sum, cout           (a+b+cin) mod 2^WIDTH and carry out of the MSB, held until next DONE

// One-bit full adder cell
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | ((x ^ y) & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nx, last;

  serial_adder_fa u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_nx)
  );

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= c_nx;
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          // hold cnt on the last bit so it never runs past WIDTH-1
          if (!last) cnt <= cnt + 1'b1;
          else begin
            sum  <= {s_bit, sum_sh[WIDTH-1:1]};
            cout <= c_nx;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  logic       clk, rst, in_valid, out_ready, cin;
  logic [7:0] a, b;
  logic       in_ready8, out_valid8, cout8;
  logic [7:0] sum8;
  logic       in_ready5, out_valid5, cout5;
  logic [4:0] sum5;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int acc8 = 0, acc5 = 0, nacc8 = 0, nacc5 = 0;
  bit ov8_d = 0, ov5_d = 0;
  logic [8:0] q8[$];
  logic [5:0] q5[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8));

  serial_adder #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
    .a(a[4:0]), .b(b[4:0]), .cin(cin), .out_valid(out_valid5), .out_ready(out_ready),
    .sum(sum5), .cout(cout5));

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: push on accepting edge, pop/compare on delivering edge.
  always @(negedge clk) begin
    logic [8:0] e8;
    if (rst) begin
      q8.delete();
      ov8_d = 0;
    end else begin
      if (out_valid8 && !ov8_d) chk("lat8", cyc - acc8, 8);
      ov8_d = out_valid8;
      if (in_valid && in_ready8) begin
        e8 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        q8.push_back(e8);
        acc8 = cyc + 1;
        nacc8++;
      end
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) chk("res8_empty", 1, 0);
        else begin
          e8 = q8.pop_front();
          chk("res8", {cout8, sum8}, e8);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e5;
    if (rst) begin
      q5.delete();
      ov5_d = 0;
    end else begin
      if (out_valid5 && !ov5_d) chk("lat5", cyc - acc5, 5);
      ov5_d = out_valid5;
      if (in_valid && in_ready5) begin
        e5 = {1'b0, a[4:0]} + {1'b0, b[4:0]} + {5'd0, cin};
        q5.push_back(e5);
        acc5 = cyc + 1;
        nacc5++;
      end
      if (out_valid5 && out_ready) begin
        if (q5.size() == 0) chk("res5_empty", 1, 0);
        else begin
          e5 = q5.pop_front();
          chk("res5", {cout5, sum5}, e5);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive operands and wait (bounded) for dut8 to accept; returns accept edge.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input bit hold, output int at);
    bit found = 0;
    a = av; b = bv; cin = cv; in_valid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready8) begin found = 1; break; end
    end
    @(posedge clk); #1;
    at = cyc;
    if (!hold) in_valid = 0;
    chk("to_accept", found, 1);
  endtask

  task automatic wait_ov8();
    for (int i = 0; i < 100; i++) begin
      if (out_valid8) break;
      step();
    end
    chk("to_outvalid", out_valid8, 1);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec);
    int at;
    out_ready = 1;
    send(av, bv, cv, 0, at);
    wait_ov8();
    chk("sum", sum8, es);
    chk("cout", cout8, ec);
    step();
  endtask

  initial begin
    int at, prev;
    bit done;
    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
    step();
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    step();
    rst = 0;

    // Basic: latency and return to IDLE
    out_ready = 1;
    send(8'h5A, 8'h3C, 0, 0, at);
    repeat (7) step();
    chk("t1_not_yet", out_valid8, 0);
    step();
    chk("t1_valid", out_valid8, 1);
    chk("t1_sum", sum8, 8'h96);
    chk("t1_cout", cout8, 0);
    step();
    chk("t1_idle_ready", in_ready8, 1);
    chk("t1_idle_ov", out_valid8, 0);

    // Carry and wrap cases
    run8(8'hFF, 8'h01, 0, 8'h00, 1);
    run8(8'hFF, 8'hFF, 1, 8'hFF, 1);
    run8(8'h00, 8'h00, 1, 8'h01, 0);

    // Backpressure with new operands offered while busy
    out_ready = 0;
    send(8'h12, 8'h34, 0, 0, at);
    wait_ov8();
    a = 8'h77; b = 8'h11; cin = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid8, 1);
      chk("bp_sum", sum8, 8'h46);
      chk("bp_cout", cout8, 0);
      chk("bp_in_ready", in_ready8, 0);
    end
    in_valid = 0; out_ready = 1;
    step();
    chk("bp_released", out_valid8, 0);
    chk("bp_ready", in_ready8, 1);
    repeat (3) step();
    chk("bp_one_result", out_valid8, 0);
    chk("bp_queue", q8.size(), 0);

    // Reset during the third RUN cycle
    send(8'hAA, 8'h55, 0, 0, at);
    step(); step();
    rst = 1; #1;
    chk("ar_ov", out_valid8, 0);
    chk("ar_ready", in_ready8, 1);
    chk("ar_sum", sum8, 0);
    chk("ar_cout", cout8, 0);
    step(); step();
    rst = 0;
    run8(8'h01, 8'h02, 0, 8'h03, 0);

    // Back-to-back throughput
    out_ready = 1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      send(8'h10 * i[7:0] + 8'h07, 8'hE3 - i[7:0], i[0], 1, at);
      if (i > 0) chk("b2b_spacing", at - prev, 10);
      prev = at;
    end
    in_valid = 0;
    repeat (15) step();
    chk("b2b_drained", q8.size(), 0);

    // Random traffic on both widths
    nacc8 = 0; nacc5 = 0;
    done = 0;
    for (int i = 0; i < 40000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      step();
      if (nacc8 >= 1000 && nacc5 >= 1000) begin done = 1; break; end
    end
    chk("rand_budget", done, 1);
    in_valid = 0; out_ready = 1;
    repeat (20) step();
    chk("rand_drain8", q8.size(), 0);
    chk("rand_drain5", q5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
